// File: rtl/xtal_seq_pkg.sv
// -----------------------------------------------------------------------------
// xtal_seq_pkg
// Shared types and constants for the crystal oscillator start-up sequencer.
//   xtalState_t    : FSM state encoding, also driven out on the State debug port
//   DEFAULT_*      : default timing constants used as parameter defaults
//   windowIsGood() : inclusive range check of a window's edge count
//   maxOf3()       : helper used to size the shared start-up/retry timer
// -----------------------------------------------------------------------------
package xtal_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BIAS    = 3'd1,
        QUALIFY = 3'd2,
        RUN     = 3'd3,
        FAULT   = 3'd4
    } xtalState_t;

    localparam int unsigned DEFAULT_STARTUP_CYCLES = 4096;
    localparam int unsigned DEFAULT_WINDOW_CYCLES  = 256;
    localparam int unsigned DEFAULT_MIN_EDGES      = 48;
    localparam int unsigned DEFAULT_MAX_EDGES      = 80;
    localparam int unsigned DEFAULT_GOOD_WINDOWS   = 4;
    localparam int unsigned DEFAULT_RETRY_CYCLES   = 1024;
    localparam int unsigned DEFAULT_MAX_RETRIES    = 3;

    // A window is good when its rising-edge count lies in [minEdges, maxEdges].
    function automatic logic windowIsGood(input int unsigned edgeCount,
                                          input int unsigned minEdges,
                                          input int unsigned maxEdges);
        return (edgeCount >= minEdges) && (edgeCount <= maxEdges);
    endfunction

    function automatic int unsigned maxOf3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/xtal_startup_sequencer_if.sv
// -----------------------------------------------------------------------------
// xtal_startup_sequencer_if
// Control/status bundle between the oscillator sequencer and its surroundings.
//   Enable      : request oscillator on (level)
//   XtalSample  : divided-down oscillator output, asynchronous to the system clock
//   OscEnable   : bias enable to the oscillator cell
//   ClockGateEn : gate enable for the ClockP/ClockN pair
//   Locked      : oscillation qualified and gate open
//   Fault       : oscillation failed qualification or was lost
//   State       : current FSM state (debug)
// master = the controlling side (drives Enable/XtalSample), slave = the sequencer.
// -----------------------------------------------------------------------------
interface xtal_startup_sequencer_if;
    logic       Enable;
    logic       XtalSample;
    logic       OscEnable;
    logic       ClockGateEn;
    logic       Locked;
    logic       Fault;
    logic [2:0] State;

    modport master (
        output Enable, XtalSample,
        input  OscEnable, ClockGateEn, Locked, Fault, State
    );

    modport slave (
        input  Enable, XtalSample,
        output OscEnable, ClockGateEn, Locked, Fault, State
    );
endinterface

// File: rtl/xtal_edge_counter.sv
// -----------------------------------------------------------------------------
// xtal_edge_counter
// Synchronises XtalSample, detects its rising edges and counts them over
// back-to-back windows of WINDOW_CYCLES clocks.
//   Clock, Reset : system clock, synchronous active-high reset
//   XtalSample   : asynchronous oscillator sample
//   measureEn    : windows run while high; held cleared while low
//   window_done  : high in the last cycle of each window
//   window_good  : edge count of the finishing window is within limits
//                  (meaningful while window_done is high)
// -----------------------------------------------------------------------------
module xtal_edge_counter
    import xtal_seq_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int unsigned MIN_EDGES     = DEFAULT_MIN_EDGES,
    parameter int unsigned MAX_EDGES     = DEFAULT_MAX_EDGES,
    parameter int unsigned TIMER_W       = $clog2(WINDOW_CYCLES)
) (
    input  logic Clock,
    input  logic Reset,
    input  logic XtalSample,
    input  logic measureEn,
    output logic window_done,
    output logic window_good
);

    localparam int unsigned        COUNT_W     = $clog2(MAX_EDGES + 2);
    localparam logic [COUNT_W-1:0] COUNT_SAT   = COUNT_W'(MAX_EDGES + 1);
    localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW_CYCLES - 1);

    // syncReg[0..1] form the synchroniser, syncReg[2] is the edge-detect delay.
    logic [2:0]         syncReg;
    logic               risingEdge;
    logic [TIMER_W-1:0] windowTimerReg, windowTimerNext;
    logic [COUNT_W-1:0] edgeCountReg, edgeCountNext;

    assign risingEdge  = syncReg[1] & ~syncReg[2];
    assign window_done = measureEn && (windowTimerReg == WINDOW_LAST);
    assign window_good = windowIsGood(32'(edgeCountReg), MIN_EDGES, MAX_EDGES);

    always_comb begin
        windowTimerNext = windowTimerReg;
        edgeCountNext   = edgeCountReg;
        if (!measureEn || window_done) begin
            // A window boundary: the edge seen this cycle opens the next window.
            // While idle every cycle is treated as a boundary, so the first
            // window after measureEn rises spans a full WINDOW_CYCLES of edges.
            windowTimerNext = '0;
            edgeCountNext   = COUNT_W'(risingEdge);
        end else begin
            windowTimerNext = windowTimerReg + 1'b1;
            // Saturate one above MAX_EDGES so an over-fast input can never wrap
            // back into the good range.
            if (risingEdge && (edgeCountReg != COUNT_SAT)) begin
                edgeCountNext = edgeCountReg + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            syncReg        <= '0;
            windowTimerReg <= '0;
            edgeCountReg   <= '0;
        end else begin
            syncReg        <= {syncReg[1:0], XtalSample};
            windowTimerReg <= windowTimerNext;
            edgeCountReg   <= edgeCountNext;
        end
    end

endmodule

// File: rtl/xtal_startup_sequencer.sv
// -----------------------------------------------------------------------------
// xtal_startup_sequencer
// Biases the crystal oscillator, waits out start-up, qualifies oscillation by
// edge counting and opens the ClockP/ClockN gate; keeps monitoring after lock.
//   Clock : system clock (always running)
//   Reset : synchronous active-high reset
//   bus   : xtal_startup_sequencer_if.slave
//           in : Enable, XtalSample
//           out: OscEnable, ClockGateEn, Locked, Fault, State[2:0]
// Build option: define XTAL_AUTO_RETRY_EN to retry from FAULT after
// RETRY_CYCLES, up to MAX_RETRIES times; otherwise FAULT is sticky until
// Enable drops or Reset.
// -----------------------------------------------------------------------------
module xtal_startup_sequencer
    import xtal_seq_pkg::*;
#(
    parameter int unsigned STARTUP_CYCLES = DEFAULT_STARTUP_CYCLES,
    parameter int unsigned WINDOW_CYCLES  = DEFAULT_WINDOW_CYCLES,
    parameter int unsigned MIN_EDGES      = DEFAULT_MIN_EDGES,
    parameter int unsigned MAX_EDGES      = DEFAULT_MAX_EDGES,
    parameter int unsigned GOOD_WINDOWS   = DEFAULT_GOOD_WINDOWS,
    parameter int unsigned RETRY_CYCLES   = DEFAULT_RETRY_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEFAULT_MAX_RETRIES
) (
    input  logic                     Clock,
    input  logic                     Reset,
    xtal_startup_sequencer_if.slave  bus
);

    localparam int unsigned TIMER_W = $clog2(maxOf3(STARTUP_CYCLES, WINDOW_CYCLES, RETRY_CYCLES));
    localparam int unsigned GOOD_W  = $clog2(GOOD_WINDOWS + 1);
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TIMER_W-1:0] STARTUP_LAST = TIMER_W'(STARTUP_CYCLES - 1);
    localparam logic [GOOD_W-1:0]  GOOD_LAST    = GOOD_W'(GOOD_WINDOWS - 1);
`ifdef XTAL_AUTO_RETRY_EN
    localparam logic [TIMER_W-1:0] RETRY_LAST   = TIMER_W'(RETRY_CYCLES - 1);
`endif

    xtalState_t         stateReg, stateNext;
    logic [TIMER_W-1:0] timerReg, timerNext;
    logic [GOOD_W-1:0]  goodCountReg, goodCountNext;
    logic [RETRY_W-1:0] retryCountReg, retryCountNext;
    logic               faultReg, faultNext;
    logic               oscEnableReg, clockGateEnReg, lockedReg;
    logic               measureEn, windowDone, windowGood;

    assign measureEn = (stateReg == QUALIFY) || (stateReg == RUN);

    xtal_edge_counter #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .MIN_EDGES     (MIN_EDGES),
        .MAX_EDGES     (MAX_EDGES),
        .TIMER_W       (TIMER_W)
    ) edgeCounter (
        .Clock       (Clock),
        .Reset       (Reset),
        .XtalSample  (bus.XtalSample),
        .measureEn   (measureEn),
        .window_done (windowDone),
        .window_good (windowGood)
    );

    always_comb begin
        stateNext      = stateReg;
        timerNext      = timerReg;
        goodCountNext  = goodCountReg;
        retryCountNext = retryCountReg;
        faultNext      = faultReg;

        unique case (stateReg)
            IDLE: begin
                if (bus.Enable) stateNext = BIAS;
            end
            BIAS: begin
                goodCountNext = '0;
                if (timerReg == STARTUP_LAST) stateNext = QUALIFY;
                else                          timerNext = timerReg + 1'b1;
            end
            QUALIFY: begin
                if (windowDone) begin
                    if (!windowGood)                    stateNext     = FAULT;
                    else if (goodCountReg == GOOD_LAST) stateNext     = RUN;
                    else                                goodCountNext = goodCountReg + 1'b1;
                end
            end
            RUN: begin
                if (windowDone && !windowGood) stateNext = FAULT;
            end
            FAULT: begin
`ifdef XTAL_AUTO_RETRY_EN
                // Timer parks at its last value once retries are exhausted.
                if (timerReg != RETRY_LAST) begin
                    timerNext = timerReg + 1'b1;
                end else if (retryCountReg < RETRY_W'(MAX_RETRIES)) begin
                    retryCountNext = retryCountReg + 1'b1;
                    stateNext      = BIAS;
                end
`endif
            end
            default: stateNext = IDLE;
        endcase

        // Dropping Enable overrides every other transition.
        if (!bus.Enable) begin
            stateNext      = IDLE;
            retryCountNext = '0;
        end

        if (stateNext == RUN) retryCountNext = '0;

        // Every state starts with a fresh timer.
        if (stateNext != stateReg) timerNext = '0;

        // Fault rises on entering FAULT and survives a retry's BIAS/QUALIFY.
        if (stateNext == FAULT)                          faultNext = 1'b1;
        else if ((stateNext == IDLE) || (stateNext == RUN)) faultNext = 1'b0;
    end

    // Outputs are registered from the next state so they change in the same
    // cycle the new state becomes visible.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateReg       <= IDLE;
            timerReg       <= '0;
            goodCountReg   <= '0;
            retryCountReg  <= '0;
            faultReg       <= 1'b0;
            oscEnableReg   <= 1'b0;
            clockGateEnReg <= 1'b0;
            lockedReg      <= 1'b0;
        end else begin
            stateReg       <= stateNext;
            timerReg       <= timerNext;
            goodCountReg   <= goodCountNext;
            retryCountReg  <= retryCountNext;
            faultReg       <= faultNext;
            oscEnableReg   <= (stateNext == BIAS) || (stateNext == QUALIFY) || (stateNext == RUN);
            clockGateEnReg <= (stateNext == RUN);
            lockedReg      <= (stateNext == RUN);
        end
    end

    assign bus.OscEnable   = oscEnableReg;
    assign bus.ClockGateEn = clockGateEnReg;
    assign bus.Locked      = lockedReg;
    assign bus.Fault       = faultReg;
    assign bus.State       = stateReg;

endmodule
